// File: rtl/zap_cache_line_fill.sv
// Wishbone 4-beat read-burst line filler with a byte-enabled store-merge path,
// both feeding a single 128-bit line RAM write port.
module zap_cache_line_fill #(
    parameter  int DEPTH = 32,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_fill_req,
    input  logic [IW-1:0] i_fill_idx,
    input  logic [31:0]   i_fill_base,
    input  logic          i_st_en,
    input  logic [IW-1:0] i_st_idx,
    input  logic [1:0]    i_st_word,
    input  logic [3:0]    i_st_sel,
    input  logic [31:0]   i_st_data,
    output logic          o_st_stall,
    output logic          o_fill_busy,
    output logic          o_fill_done,
    output logic          o_fill_err,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic [31:0]   o_wb_adr,
    output logic [2:0]    o_wb_cti,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic [31:0]   i_wb_dat,
    output logic [15:0]   o_ram_ben,
    output logic [IW-1:0] o_ram_waddr,
    output logic [127:0]  o_ram_wdata
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_COMMIT} state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [127:0]   line_q, line_d;
    logic           wb_cyc_q, wb_cyc_d;
    logic           wb_stb_q, wb_stb_d;
    logic [31:0]    wb_adr_q, wb_adr_d;
    logic [2:0]     wb_cti_q, wb_cti_d;
    logic [15:0]    ram_ben_q, ram_ben_d;
    logic [IW-1:0]  ram_waddr_q, ram_waddr_d;
    logic [127:0]   ram_wdata_q, ram_wdata_d;
    logic           fill_done_q, fill_done_d;
    logic           fill_err_q, fill_err_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (i_fill_req) state_d = S_BURST;
            S_BURST: begin
                if (i_wb_err)                       state_d = S_IDLE;
                else if (i_wb_ack && cnt_q == 2'd3) state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        line_d      = line_q;
        wb_cyc_d    = wb_cyc_q;
        wb_stb_d    = wb_stb_q;
        wb_adr_d    = wb_adr_q;
        wb_cti_d    = wb_cti_q;
        ram_ben_d   = 16'h0000;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        fill_done_d = 1'b0;
        fill_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_st_en) begin
                    ram_ben_d   = {12'd0, i_st_sel} << {i_st_word, 2'b00};
                    ram_waddr_d = i_st_idx;
                    ram_wdata_d = {4{i_st_data}};
                end
                if (i_fill_req) begin
                    idx_d    = i_fill_idx;
                    cnt_d    = 2'd0;
                    wb_cyc_d = 1'b1;
                    wb_stb_d = 1'b1;
                    wb_adr_d = i_fill_base & 32'hFFFF_FFF0;
                    wb_cti_d = 3'b010;
                end
            end
            S_BURST: begin
                // Error wins over a simultaneous ack; the partial line is simply abandoned.
                if (i_wb_err) begin
                    cnt_d      = 2'd0;
                    wb_cyc_d   = 1'b0;
                    wb_stb_d   = 1'b0;
                    wb_adr_d   = 32'd0;
                    wb_cti_d   = 3'b000;
                    fill_err_d = 1'b1;
                end else if (i_wb_ack) begin
                    line_d[{cnt_q, 5'd0} +: 32] = i_wb_dat;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        wb_cyc_d    = 1'b0;
                        wb_stb_d    = 1'b0;
                        wb_adr_d    = 32'd0;
                        wb_cti_d    = 3'b000;
                        ram_ben_d   = 16'hFFFF;
                        ram_waddr_d = idx_q;
                        ram_wdata_d = {i_wb_dat, line_q[95:0]};
                        fill_done_d = 1'b1;
                    end else begin
                        wb_adr_d = wb_adr_q + 32'd4;
                        wb_cti_d = (cnt_q == 2'd2) ? 3'b111 : 3'b010;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            line_q      <= '0;
            wb_cyc_q    <= 1'b0;
            wb_stb_q    <= 1'b0;
            wb_adr_q    <= '0;
            wb_cti_q    <= '0;
            ram_ben_q   <= '0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            fill_done_q <= 1'b0;
            fill_err_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            wb_cyc_q    <= wb_cyc_d;
            wb_stb_q    <= wb_stb_d;
            wb_adr_q    <= wb_adr_d;
            wb_cti_q    <= wb_cti_d;
            ram_ben_q   <= ram_ben_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            fill_done_q <= fill_done_d;
            fill_err_q  <= fill_err_d;
        end
    end

    assign o_fill_busy = (state_q != S_IDLE);
    assign o_st_stall  = i_st_en && (state_q != S_IDLE);
    assign o_fill_done = fill_done_q;
    assign o_fill_err  = fill_err_q;
    assign o_wb_cyc    = wb_cyc_q;
    assign o_wb_stb    = wb_stb_q;
    assign o_wb_adr    = wb_adr_q;
    assign o_wb_cti    = wb_cti_q;
    assign o_ram_ben   = ram_ben_q;
    assign o_ram_waddr = ram_waddr_q;
    assign o_ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_zap_cache_line_fill.sv
// Scoreboard bench for zap_cache_line_fill: the stimulus process plays requester and
// Wishbone slave and queues expected RAM-port events; a negedge monitor checks them.
module tb_zap_cache_line_fill;
    localparam int DEPTH = 32;
    localparam int IW    = $clog2(DEPTH);

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_fill_req = 1'b0;
    logic [IW-1:0] i_fill_idx = '0;
    logic [31:0]   i_fill_base = '0;
    logic          i_st_en = 1'b0;
    logic [IW-1:0] i_st_idx = '0;
    logic [1:0]    i_st_word = '0;
    logic [3:0]    i_st_sel = '0;
    logic [31:0]   i_st_data = '0;
    logic          o_st_stall, o_fill_busy, o_fill_done, o_fill_err;
    logic          o_wb_cyc, o_wb_stb;
    logic [31:0]   o_wb_adr;
    logic [2:0]    o_wb_cti;
    logic          i_wb_ack = 1'b0;
    logic          i_wb_err = 1'b0;
    logic [31:0]   i_wb_dat = '0;
    logic [15:0]   o_ram_ben;
    logic [IW-1:0] o_ram_waddr;
    logic [127:0]  o_ram_wdata;

    zap_cache_line_fill #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_fill_req(i_fill_req), .i_fill_idx(i_fill_idx), .i_fill_base(i_fill_base),
        .i_st_en(i_st_en), .i_st_idx(i_st_idx), .i_st_word(i_st_word),
        .i_st_sel(i_st_sel), .i_st_data(i_st_data),
        .o_st_stall(o_st_stall), .o_fill_busy(o_fill_busy),
        .o_fill_done(o_fill_done), .o_fill_err(o_fill_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_adr(o_wb_adr), .o_wb_cti(o_wb_cti),
        .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat),
        .o_ram_ben(o_ram_ben), .o_ram_waddr(o_ram_waddr), .o_ram_wdata(o_ram_wdata)
    );

    always #5 i_clk = ~i_clk;

    // kind: 0 = store write, 1 = completed fill (write + done), 2 = aborted fill (err pulse)
    typedef struct {
        int            kind;
        logic [15:0]   ben;
        logic [IW-1:0] waddr;
        logic [127:0]  wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    always @(negedge i_clk) begin
        if (!i_reset && (o_ram_ben != 16'd0 || o_fill_done || o_fill_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {o_fill_err, o_fill_done, o_ram_ben}, 128'd0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn kind=%0d ben=%h waddr=%0d done=%0b err=%0b",
                         mon_e.kind, o_ram_ben, o_ram_waddr, o_fill_done, o_fill_err);
                chk("mon_ben", o_ram_ben, mon_e.ben);
                chk("mon_done", o_fill_done, mon_e.kind == 1);
                chk("mon_err", o_fill_err, mon_e.kind == 2);
                if (mon_e.kind != 2) begin
                    chk("mon_waddr", o_ram_waddr, mon_e.waddr);
                    chk("mon_wdata", o_ram_wdata, mon_e.wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic prep_store(input logic [IW-1:0] idx, input logic [1:0] word,
                              input logic [3:0] sel, input logic [31:0] data);
        exp_t e;
        i_st_en = 1'b1; i_st_idx = idx; i_st_word = word; i_st_sel = sel; i_st_data = data;
        e.kind  = 0;
        e.waddr = idx;
        e.wdata = {4{data}};
        for (int b = 0; b < 16; b++) e.ben[b] = ((b / 4) == int'(word)) && sel[b % 4];
        exp_q.push_back(e);
    endtask

    task automatic do_store(input logic [IW-1:0] idx, input logic [1:0] word,
                            input logic [3:0] sel, input logic [31:0] data);
        prep_store(idx, word, sel, data);
        #1 chk("stall_idle", o_st_stall, 1'b0);
        tick();
        i_st_en = 1'b0;
    endtask

    // Drives a fill and answers it as the slave. err_beat/rst_beat < 0 means none.
    task automatic do_fill(input logic [IW-1:0] idx, input logic [31:0] base, input int waits,
                           input int err_beat, input int rst_beat, input bit probe,
                           input logic [127:0] line);
        exp_t        e;
        logic [31:0] abase;
        abase   = {base[31:4], 4'h0};
        e.kind  = (err_beat >= 0) ? 2 : 1;
        e.ben   = (err_beat >= 0) ? 16'h0000 : 16'hFFFF;
        e.waddr = idx;
        e.wdata = line;
        if (rst_beat < 0) exp_q.push_back(e);
        $display("fill idx=%0d base=%h waits=%0d err_beat=%0d rst_beat=%0d", idx, base, waits, err_beat, rst_beat);
        i_fill_req = 1'b1; i_fill_idx = idx; i_fill_base = base;
        tick();
        i_fill_req = 1'b0; i_st_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w <= waits; w++) begin
                i_st_en = probe; i_st_idx = IW'($urandom); i_st_sel = 4'hF; i_st_word = 2'($urandom);
                i_wb_dat = $urandom;
                #1;
                chk("bus_cyc", o_wb_cyc, 1'b1);
                chk("bus_stb", o_wb_stb, 1'b1);
                chk("bus_adr", o_wb_adr, abase + 32'(4 * k));
                chk("bus_cti", o_wb_cti, (k == 3) ? 3'b111 : 3'b010);
                chk("busy_burst", o_fill_busy, 1'b1);
                if (probe) chk("stall_burst", o_st_stall, 1'b1);
                if (w == waits) begin
                    i_wb_ack = 1'b1;
                    i_wb_dat = line[32*k +: 32];
                    if (k == err_beat) i_wb_err = 1'b1;
                end
                tick();
                i_wb_ack = 1'b0; i_wb_err = 1'b0;
            end
            if (k == err_beat) begin
                i_st_en = 1'b0;
                #1;
                chk("err_cyc", o_wb_cyc, 1'b0);
                chk("err_pulse", o_fill_err, 1'b1);
                chk("err_ben", o_ram_ben, 16'd0);
                chk("err_busy", o_fill_busy, 1'b0);
                tick();
                chk("err_pulse_end", o_fill_err, 1'b0);
                return;
            end
            if (k == rst_beat) begin
                i_st_en = 1'b0;
                i_reset = 1'b1;
                #1;
                chk("rst_async_bus", {o_wb_cyc, o_wb_stb, o_wb_adr, o_wb_cti}, 128'd0);
                chk("rst_async_ram", {o_ram_ben, o_ram_waddr}, 128'd0);
                chk("rst_async_wdata", o_ram_wdata, 128'd0);
                chk("rst_async_flags", {o_fill_done, o_fill_err, o_fill_busy}, 128'd0);
                tick();
                return;
            end
        end
        i_st_en = 1'b0;
        #1;
        chk("done_latency", o_fill_done, 1'b1);
        chk("commit_busy", o_fill_busy, 1'b1);
        chk("commit_cyc", o_wb_cyc, 1'b0);
        i_fill_req = 1'b1;
        tick();
        i_fill_req = 1'b0;
        #1;
        chk("done_pulse_end", o_fill_done, 1'b0);
        chk("idle_ben", o_ram_ben, 16'd0);
        chk("commit_req_ignored", o_fill_busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ln;
        tick();
        #1;
        chk("reset_bus", {o_wb_cyc, o_wb_stb, o_wb_adr, o_wb_cti}, 128'd0);
        chk("reset_ram", {o_ram_ben, o_fill_done, o_fill_err, o_fill_busy}, 128'd0);
        tick();
        i_reset = 1'b0;

        // Directed zero-wait fill, requested on the first edge after reset release.
        do_fill(5, 32'h1000_0004, 0, -1, -1, 1'b0,
                128'h44444444_33333333_22222222_11111111);
        // Same fill with three wait cycles per beat.
        do_fill(5, 32'h1000_0004, 3, -1, -1, 1'b0,
                128'h44444444_33333333_22222222_11111111);
        // Error on beat 2.
        do_fill(7, 32'h2000_0010, 0, 2, -1, 1'b0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
        // Idle store.
        prep_store(3, 2'd2, 4'b0110, 32'hAABB_CCDD);
        #1 chk("stall_idle", o_st_stall, 1'b0);
        tick();
        i_st_en = 1'b0;
        #1;
        chk("store_ben", o_ram_ben, 16'h0600);
        chk("store_waddr", o_ram_waddr, 5'd3);
        // Stores probed while the burst is in progress.
        do_fill(9, 32'h3000_0020, 1, -1, -1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
        // Reset after beat 1 ack, then an immediate new fill.
        do_fill(11, 32'h4000_0030, 0, -1, 1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        i_reset = 1'b0;
        do_fill(12, 32'h4000_0040, 0, -1, -1, 1'b0, {$urandom, $urandom, $urandom, $urandom});

        for (int n = 0; n < 40; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            ln = {$urandom, $urandom, $urandom, $urandom};
            if (op < 3) begin
                do_store(IW'($urandom), 2'($urandom), 4'($urandom_range(1, 15)), $urandom);
            end else begin
                if (op == 3)
                    prep_store(IW'($urandom), 2'($urandom), 4'($urandom_range(1, 15)), $urandom);
                do_fill(IW'($urandom), $urandom, int'($urandom_range(0, 2)),
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                        -1, 1'($urandom), ln);
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        tick();
        tick();
        chk("queue_empty", exp_q.size(), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zap_cache_line_fill.md
ZAP_CACHE_LINE_FILL -- requirements
Module: zap_cache_line_fill

Interface
REQ-001 Parameter DEPTH, default 32, number of 128-bit lines in the downstream byte-enabled line RAM; IW = $clog2(DEPTH).
REQ-002 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 i_reset  input  1  reset, asynchronous and active-high.
REQ-004 i_fill_req  input  1  single-cycle fill strobe; ignored unless state IDLE.
REQ-005 i_fill_idx  input  IW  destination line index, captured with i_fill_req.
REQ-006 i_fill_base  input  32  line byte address, captured with i_fill_req; bits [3:0] forced to 0 on capture.
REQ-007 i_st_en, i_st_idx[IW-1:0], i_st_word[1:0], i_st_sel[3:0], i_st_data[31:0]  inputs  store-merge request: line, word in line, byte selects, data.
REQ-008 o_st_stall  output  1  store not accepted this cycle.
REQ-009 o_fill_busy  output  1  high in BURST and COMMIT.
REQ-010 o_fill_done, o_fill_err  outputs  1  single-cycle completion / abort pulses.
REQ-011 o_wb_cyc, o_wb_stb  outputs  1; o_wb_adr  output  32; o_wb_cti  output  3  Wishbone read burst master (read-only, no we).
REQ-012 i_wb_ack, i_wb_err  input  1; i_wb_dat  input  32  Wishbone slave response.
REQ-013 o_ram_ben  output  16; o_ram_waddr  output  IW; o_ram_wdata  output  128  line RAM write port (byte k enables bits [8k+7:8k]).

Function
REQ-014 States SHALL be IDLE, BURST, COMMIT; all outputs except o_st_stall and o_fill_busy SHALL be registered.
REQ-015 IDLE + i_fill_req: capture idx/base, beat counter=0, next cycle state BURST with o_wb_cyc=o_wb_stb=1, o_wb_adr=base, o_wb_cti=3'b010.
REQ-016 BURST + i_wb_ack: word i_wb_dat stored to line bits [32*cnt+31:32*cnt], cnt increments, o_wb_adr advances by 4; o_wb_cti becomes 3'b111 when the issued beat is beat 3.
REQ-017 Cycles in BURST without ack or err SHALL hold all bus outputs and line contents unchanged (unbounded wait).
REQ-018 Ack on beat 3: next cycle state COMMIT, o_wb_cyc=o_wb_stb=0, o_wb_cti=0, o_ram_ben=16'hFFFF, o_ram_waddr=captured idx, o_ram_wdata=assembled line, o_fill_done=1.
REQ-019 COMMIT lasts exactly one cycle; next cycle IDLE with o_ram_ben=0, o_fill_done=0; i_fill_req during COMMIT ignored.
REQ-020 i_wb_err in BURST (takes priority over simultaneous ack): next cycle IDLE, bus outputs 0, o_fill_err=1 for one cycle, o_ram_ben=0 (no RAM write).
REQ-021 Store path: o_st_stall = i_st_en AND state != IDLE.
REQ-022 IDLE + i_st_en: next cycle o_ram_ben = i_st_sel << (4*i_st_word), o_ram_waddr=i_st_idx, o_ram_wdata={4{i_st_data}}, for one cycle.
REQ-023 IDLE with i_st_en and i_fill_req same cycle: both accepted; store write as REQ-022, fill proceeds as REQ-015; ordering hazards on the same line are the requester's responsibility.
REQ-024 IDLE without i_st_en: o_ram_ben=0 next cycle; o_ram_waddr/o_ram_wdata don't-care when o_ram_ben=0.
REQ-025 Fill latency with zero-wait ack: strobe cycle T, beats acked T+1..T+4, o_fill_done and RAM write at T+5, IDLE at T+6.

Reset
REQ-026 i_reset asserted SHALL immediately force state IDLE, counter 0, all registered outputs 0 (o_wb_*, o_ram_*, o_fill_done, o_fill_err).
REQ-027 Reset mid-burst SHALL discard partial line and produce no RAM write, done or err pulse.
REQ-028 First i_fill_req SHALL be accepted on the first rising edge after i_reset deasserts.

Verification
REQ-029 Fill idx=5, base=32'h1000_0004, ack every cycle, data 11111111/22222222/33333333/44444444 -> adr 1000_0000,04,08,0C; cti 010,010,010,111; one cycle ben=FFFF waddr=5 wdata=44444444_33333333_22222222_11111111, o_fill_done=1.
REQ-030 Same fill with 3 wait cycles before each ack -> outputs held during waits; identical RAM write; done at T+17.
REQ-031 i_wb_err on beat 2 -> o_fill_err pulse, ben never non-zero, cyc=0 next cycle, state IDLE.
REQ-032 Idle store idx=3, word=2, sel=4'b0110, data=AABBCCDD -> next cycle ben=16'h0600, waddr=3; store during BURST -> o_st_stall=1, no write.
REQ-033 i_reset asserted after beat 1 ack -> all outputs 0 asynchronously; no RAM write; new fill after release completes normally.
